// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, the
// opcodes it decodes, datapath select encodings and trap cause codes.
package multicycle_control_pkg;

  typedef enum logic [4:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_LINK,
    S_LINK_WB,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_PC_OLD = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive bus wait cycles and flags expiry on the N-th one.
// Ports: clk, reset (sync, active-high), clear (restart count),
//        enable (a wait cycle is happening), expired (this wait cycle is the N-th).
module bus_timeout_counter #(
  parameter int unsigned N = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] count;

  // count holds the number of wait cycles already completed
  assign expired = enable && (count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes as a decode of the current state.
// Ports: clk, reset (sync, active-high); opcode/funct3 from IR; mem_ready;
//        datapath strobes and selects; trap/trap_cause; retire pulse and count.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT     = 0,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        lord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_source,
  output logic        memory_to_reg,
  output logic        reg_write,
  output logic        is_immediate,
  output logic        branch_negate,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  aluop,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        retire,
  output logic [31:0] retire_count
);

  state_t     state, next_state;
  logic [1:0] next_cause;
  logic       skip_retire_c;
  logic       timeout_c;
  logic       do_retire_c;
  logic       mem_read_c, mem_write_c, ir_write_c, pc_write_c, pc_write_cond_c, reg_write_c;
  logic       unused_funct3;

  assign unused_funct3 = funct3[1];

  // Bus wait timer, only present when a timeout is configured
  if (MEM_TIMEOUT > 0) begin : g_timeout
    logic bus_wait_c, clear_c, enable_c;
    assign bus_wait_c = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign enable_c   = bus_wait_c && !mem_ready;
    assign clear_c    = mem_ready || (next_state != state);
    bus_timeout_counter #(.N(MEM_TIMEOUT)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_c),
      .enable  (enable_c),
      .expired (timeout_c)
    );
  end else begin : g_no_timeout
    assign timeout_c = 1'b0;
  end

  // Next-state logic; mem_ready beats a same-cycle timeout
  always_comb begin
    next_state    = state;
    next_cause    = CAUSE_NONE;
    skip_retire_c = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          next_state = S_DECODE;
        end else if (timeout_c) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OPCODE_OP:     next_state = S_EXEC_R;
          OPCODE_OP_IMM: next_state = S_EXEC_I;
          OPCODE_LOAD,
          OPCODE_STORE:  next_state = S_MEM_ADDR;
          OPCODE_BRANCH: next_state = S_BRANCH;
          OPCODE_JAL:    next_state = S_JAL;
          OPCODE_JALR:   next_state = S_JALR;
          OPCODE_LUI:    next_state = S_LUI;
          OPCODE_AUIPC:  next_state = S_AUIPC;
          OPCODE_FENCE:  next_state = S_FETCH;
          OPCODE_SYSTEM: begin
            next_state = S_TRAP;
            next_cause = CAUSE_SYSTEM;
          end
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              next_state = S_TRAP;
              next_cause = CAUSE_ILLEGAL;
            end else begin
              // an illegal opcode run as NOP is dropped, not counted as retired
              next_state    = S_FETCH;
              skip_retire_c = 1'b1;
            end
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: next_state = S_ALU_WB;
      S_ALU_WB, S_LINK_WB, S_MEM_WB, S_BRANCH: next_state = S_FETCH;
      S_MEM_ADDR: next_state = (opcode == OPCODE_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          next_state = (state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end else if (timeout_c) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_JAL:       next_state = S_LINK_WB;
      S_JALR:      next_state = S_JALR_LINK;
      S_JALR_LINK: next_state = S_LINK_WB;
      S_TRAP:      next_state = S_TRAP;
      default:     next_state = S_FETCH;
    endcase
  end

  assign do_retire_c = (next_state == S_FETCH) && (state != S_FETCH) &&
                       (state != S_TRAP) && !skip_retire_c;

  // State, trap cause and retire bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      trap_cause   <= CAUSE_NONE;
      retire       <= 1'b0;
      retire_count <= '0;
    end else begin
      state  <= next_state;
      retire <= do_retire_c;
      if (do_retire_c) begin
        retire_count <= retire_count + 32'd1;
      end
      if ((next_state == S_TRAP) && (state != S_TRAP)) begin
        trap_cause <= next_cause;
      end
    end
  end

  // Output decode of the current state
  always_comb begin
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    reg_write_c     = 1'b0;
    lord            = 1'b0;
    pc_source       = 1'b0;
    memory_to_reg   = 1'b0;
    is_immediate    = 1'b0;
    branch_negate   = 1'b0;
    alu_src_a       = SRC_A_PC;
    alu_src_b       = SRC_B_RS2;
    aluop           = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_read_c = 1'b1;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        alu_src_b  = SRC_B_FOUR;
      end
      S_DECODE, S_AUIPC: begin
        alu_src_a = SRC_A_PC_OLD;
        alu_src_b = SRC_B_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        aluop     = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        aluop        = ALUOP_FUNCT;
        is_immediate = 1'b1;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
      end
      S_ALU_WB, S_LINK_WB: reg_write_c = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        lord       = 1'b1;
        mem_read_c = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_c   = 1'b1;
        memory_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        lord        = 1'b1;
        mem_write_c = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = SRC_A_RS1;
        aluop           = ALUOP_BRANCH;
        pc_write_cond_c = 1'b1;
        pc_source       = 1'b1;
        branch_negate   = funct3[0] ^ funct3[2];
      end
      S_JAL: begin
        pc_write_c = 1'b1;
        pc_source  = 1'b1;
        alu_src_a  = SRC_A_PC_OLD;
        alu_src_b  = SRC_B_FOUR;
      end
      S_JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        pc_write_c = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a = SRC_A_PC_OLD;
        alu_src_b = SRC_B_FOUR;
      end
      default: ;
    endcase
  end

  assign trap = (state == S_TRAP);

  // Architectural write strobes are held off while reset is asserted
  assign mem_read      = mem_read_c      && !reset;
  assign mem_write     = mem_write_c     && !reset;
  assign ir_write      = ir_write_c      && !reset;
  assign pc_write      = pc_write_c      && !reset;
  assign pc_write_cond = pc_write_cond_c && !reset;
  assign reg_write     = reg_write_c     && !reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a directed cycle table, hand-written timeout,
// illegal-opcode and reset sequences, and randomized instruction streams
// checked against an instruction-timing model.
module tb_multicycle_control;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_ILL   = 7'b1111111;

  // {mem_read mem_write lord ir_write pc_write pc_write_cond pc_source
  //  memory_to_reg reg_write is_immediate branch_negate, a, b, aluop, trap}
  localparam logic [17:0] E_FW    = 18'b10000000000_00_01_00_0;
  localparam logic [17:0] E_FG    = 18'b10011000000_00_01_00_0;
  localparam logic [17:0] E_DEC   = 18'b00000000000_10_10_00_0;
  localparam logic [17:0] E_EXR   = 18'b00000000000_01_00_10_0;
  localparam logic [17:0] E_EXI   = 18'b00000000010_01_10_10_0;
  localparam logic [17:0] E_WB    = 18'b00000000100_00_00_00_0;
  localparam logic [17:0] E_MADDR = 18'b00000000000_01_10_00_0;
  localparam logic [17:0] E_MRD   = 18'b10100000000_00_00_00_0;
  localparam logic [17:0] E_MWB   = 18'b00000001100_00_00_00_0;
  localparam logic [17:0] E_MWR   = 18'b01100000000_00_00_00_0;
  localparam logic [17:0] E_BR0   = 18'b00000110000_01_00_01_0;
  localparam logic [17:0] E_BR1   = 18'b00000110001_01_00_01_0;
  localparam logic [17:0] E_JAL   = 18'b00001010000_10_01_00_0;
  localparam logic [17:0] E_JALR  = 18'b00001000000_01_10_00_0;
  localparam logic [17:0] E_JLINK = 18'b00000000000_10_01_00_0;
  localparam logic [17:0] E_LUI   = 18'b00000000000_11_10_00_0;
  localparam logic [17:0] E_AUIPC = 18'b00000000000_10_10_00_0;
  localparam logic [17:0] E_TRAP  = 18'b00000000000_00_00_00_1;
  localparam logic [17:0] E_RST   = 18'b00000000000_00_01_00_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: default parameters
  logic r0, rdy0;
  logic [6:0] op0;
  logic [2:0] f0;
  logic d0_mem_read, d0_mem_write, d0_lord, d0_ir_write, d0_pc_write, d0_pc_write_cond;
  logic d0_pc_source, d0_memory_to_reg, d0_reg_write, d0_is_immediate, d0_branch_negate;
  logic [1:0] d0_a, d0_b, d0_aluop, d0_trap_cause;
  logic d0_trap, d0_retire;
  logic [31:0] d0_retire_count;

  // dut1: timeout of 4 cycles, illegal opcodes run as NOP
  logic r1, rdy1;
  logic [6:0] op1;
  logic [2:0] f1;
  logic d1_mem_read, d1_mem_write, d1_lord, d1_ir_write, d1_pc_write, d1_pc_write_cond;
  logic d1_pc_source, d1_memory_to_reg, d1_reg_write, d1_is_immediate, d1_branch_negate;
  logic [1:0] d1_a, d1_b, d1_aluop, d1_trap_cause;
  logic d1_trap, d1_retire;
  logic [31:0] d1_retire_count;

  multicycle_control dut0 (
    .clk(clk), .reset(r0), .opcode(op0), .funct3(f0), .mem_ready(rdy0),
    .mem_read(d0_mem_read), .mem_write(d0_mem_write), .lord(d0_lord),
    .ir_write(d0_ir_write), .pc_write(d0_pc_write), .pc_write_cond(d0_pc_write_cond),
    .pc_source(d0_pc_source), .memory_to_reg(d0_memory_to_reg), .reg_write(d0_reg_write),
    .is_immediate(d0_is_immediate), .branch_negate(d0_branch_negate),
    .alu_src_a(d0_a), .alu_src_b(d0_b), .aluop(d0_aluop), .trap(d0_trap),
    .trap_cause(d0_trap_cause), .retire(d0_retire), .retire_count(d0_retire_count)
  );

  multicycle_control #(.MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .reset(r1), .opcode(op1), .funct3(f1), .mem_ready(rdy1),
    .mem_read(d1_mem_read), .mem_write(d1_mem_write), .lord(d1_lord),
    .ir_write(d1_ir_write), .pc_write(d1_pc_write), .pc_write_cond(d1_pc_write_cond),
    .pc_source(d1_pc_source), .memory_to_reg(d1_memory_to_reg), .reg_write(d1_reg_write),
    .is_immediate(d1_is_immediate), .branch_negate(d1_branch_negate),
    .alu_src_a(d1_a), .alu_src_b(d1_b), .aluop(d1_aluop), .trap(d1_trap),
    .trap_cause(d1_trap_cause), .retire(d1_retire), .retire_count(d1_retire_count)
  );

  wire [17:0] v0 = {d0_mem_read, d0_mem_write, d0_lord, d0_ir_write, d0_pc_write,
                    d0_pc_write_cond, d0_pc_source, d0_memory_to_reg, d0_reg_write,
                    d0_is_immediate, d0_branch_negate, d0_a, d0_b, d0_aluop, d0_trap};
  wire [17:0] v1 = {d1_mem_read, d1_mem_write, d1_lord, d1_ir_write, d1_pc_write,
                    d1_pc_write_cond, d1_pc_source, d1_memory_to_reg, d1_reg_write,
                    d1_is_immediate, d1_branch_negate, d1_a, d1_b, d1_aluop, d1_trap};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        rdy;
    logic [17:0] exp;
    logic        ret;
  } row_t;
  row_t rows[$];

  typedef struct {
    logic rdy;
    logic mr;
    logic mw;
  } cyc_t;
  cyc_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic rdy,
                     input logic [17:0] e, input logic ret);
    row_t r;
    r.op = op; r.f3 = f3; r.rdy = rdy; r.exp = e; r.ret = ret;
    rows.push_back(r);
  endtask

  // Applies the row table to dut0 one cycle per row, tracking expected retirements
  task automatic run_rows(input string tag);
    int cnt;
    cnt = 0;
    foreach (rows[i]) begin
      op0 = rows[i].op; f0 = rows[i].f3; rdy0 = rows[i].rdy;
      #2;
      if (rows[i].ret) cnt++;
      chk($sformatf("%s_row%0d", tag, i), {13'd0, v0, d0_retire, d0_retire_count},
          {13'd0, rows[i].exp, rows[i].ret, 32'(cnt)});
      tick();
    end
    rows.delete();
  endtask

  // One dut1 cycle with full output check
  task automatic s1(input string nm, input logic [6:0] op, input logic rdy,
                    input logic [17:0] e, input logic [1:0] cause);
    op1 = op; f1 = 3'd0; rdy1 = rdy;
    #2;
    chk(nm, {v1, d1_trap_cause, d1_retire, d1_retire_count}, {e, cause, 1'b0, 32'd0});
    tick();
  endtask

  task automatic reset0(input string nm);
    r0 = 1'b1; rdy0 = 1'b1; op0 = OP_R; f0 = 3'd0;
    tick();
    #2;
    chk(nm, {v0, d0_trap_cause, d0_retire, d0_retire_count}, {E_RST, 2'b00, 1'b0, 32'd0});
    r0 = 1'b0;
  endtask

  task automatic reset1(input string nm);
    r1 = 1'b1; rdy1 = 1'b1; op1 = OP_R; f1 = 3'd0;
    tick();
    #2;
    chk(nm, {v1, d1_trap_cause, d1_retire, d1_retire_count}, {E_RST, 2'b00, 1'b0, 32'd0});
    r1 = 1'b0;
  endtask

  logic [6:0] rop;
  logic [2:0] rf3;
  int k, w1, w2, mcnt;
  bit first;
  logic exp_ret;

  initial begin
    r0 = 1'b1; r1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
    op0 = OP_R; op1 = OP_R; f0 = 3'd0; f1 = 3'd0;
    tick();

    // ---- directed cycle table on dut0
    reset0("reset_hold");
    add(OP_R, 0, 1, E_FG, 0);   add(OP_R, 0, 1, E_DEC, 0);
    add(OP_R, 0, 1, E_EXR, 0);  add(OP_R, 0, 1, E_WB, 0);
    add(OP_LD, 2, 1, E_FG, 1);  add(OP_LD, 2, 1, E_DEC, 0);  add(OP_LD, 2, 1, E_MADDR, 0);
    add(OP_LD, 2, 0, E_MRD, 0); add(OP_LD, 2, 0, E_MRD, 0);  add(OP_LD, 2, 0, E_MRD, 0);
    add(OP_LD, 2, 1, E_MRD, 0); add(OP_LD, 2, 1, E_MWB, 0);
    add(OP_BR, 1, 1, E_FG, 1);  add(OP_BR, 1, 1, E_DEC, 0);  add(OP_BR, 1, 1, E_BR1, 0);
    add(OP_BR, 5, 1, E_FG, 1);  add(OP_BR, 5, 1, E_DEC, 0);  add(OP_BR, 5, 1, E_BR0, 0);
    add(OP_JALR, 0, 1, E_FG, 1); add(OP_JALR, 0, 1, E_DEC, 0); add(OP_JALR, 0, 1, E_JALR, 0);
    add(OP_JALR, 0, 1, E_JLINK, 0); add(OP_JALR, 0, 1, E_WB, 0);
    add(OP_JAL, 0, 1, E_FG, 1); add(OP_JAL, 0, 1, E_DEC, 0);
    add(OP_JAL, 0, 1, E_JAL, 0); add(OP_JAL, 0, 1, E_WB, 0);
    add(OP_LUI, 0, 1, E_FG, 1); add(OP_LUI, 0, 1, E_DEC, 0);
    add(OP_LUI, 0, 1, E_LUI, 0); add(OP_LUI, 0, 1, E_WB, 0);
    add(OP_AUIPC, 0, 1, E_FG, 1); add(OP_AUIPC, 0, 1, E_DEC, 0);
    add(OP_AUIPC, 0, 1, E_AUIPC, 0); add(OP_AUIPC, 0, 1, E_WB, 0);
    add(OP_I, 0, 1, E_FG, 1);   add(OP_I, 0, 1, E_DEC, 0);
    add(OP_I, 0, 1, E_EXI, 0);  add(OP_I, 0, 1, E_WB, 0);
    add(OP_ST, 2, 0, E_FW, 1);  add(OP_ST, 2, 1, E_FG, 0);   add(OP_ST, 2, 1, E_DEC, 0);
    add(OP_ST, 2, 1, E_MADDR, 0); add(OP_ST, 2, 0, E_MWR, 0); add(OP_ST, 2, 1, E_MWR, 0);
    add(OP_FENCE, 0, 1, E_FG, 1); add(OP_FENCE, 0, 1, E_DEC, 0);
    add(OP_ILL, 0, 1, E_FG, 1); add(OP_ILL, 0, 1, E_DEC, 0);
    add(OP_ILL, 0, 1, E_TRAP, 0); add(OP_ILL, 0, 0, E_TRAP, 0);
    run_rows("seq");
    #2;
    chk("illegal_cause", {30'd0, d0_trap_cause}, 32'd1);
    reset0("reset_from_trap");

    add(OP_SYS, 0, 1, E_FG, 0); add(OP_SYS, 0, 1, E_DEC, 0); add(OP_SYS, 0, 1, E_TRAP, 0);
    run_rows("sys");
    #2;
    chk("system_cause", {30'd0, d0_trap_cause}, 32'd3);

    // ---- timeout and illegal-as-NOP on dut1
    reset1("reset1_hold");
    for (int i = 0; i < 4; i++) s1($sformatf("tmo_wait%0d", i), OP_R, 1'b0, E_FW, 2'b00);
    s1("tmo_trap", OP_R, 1'b0, E_TRAP, 2'b10);
    s1("tmo_trap_hold", OP_R, 1'b1, E_TRAP, 2'b10);
    reset1("reset1_from_trap");
    for (int i = 0; i < 3; i++) s1($sformatf("edge_wait%0d", i), OP_ILL, 1'b0, E_FW, 2'b00);
    s1("edge_ready", OP_ILL, 1'b1, E_FG, 2'b00);
    s1("ill_decode", OP_ILL, 1'b1, E_DEC, 2'b00);
    s1("ill_nop_fetch", OP_LD, 1'b0, E_FW, 2'b00);
    s1("lw_fetch", OP_LD, 1'b1, E_FG, 2'b00);
    s1("lw_decode", OP_LD, 1'b1, E_DEC, 2'b00);
    s1("lw_addr", OP_LD, 1'b0, E_MADDR, 2'b00);
    for (int i = 0; i < 4; i++) s1($sformatf("lw_wait%0d", i), OP_LD, 1'b0, E_MRD, 2'b00);
    s1("lw_tmo_trap", OP_LD, 1'b0, E_TRAP, 2'b10);

    // ---- random instruction stream on dut0 against an instruction-timing model
    reset0("reset_rand");
    mcnt = 0;
    first = 1'b1;
    for (int n = 0; n < 300; n++) begin
      k   = int'($urandom_range(0, 9));
      rf3 = 3'($urandom);
      w1  = int'($urandom_range(0, 3));
      w2  = int'($urandom_range(0, 3));
      q.delete();
      for (int j = 0; j < w1; j++) q.push_back('{1'b0, 1'b1, 1'b0});
      q.push_back('{1'b1, 1'b1, 1'b0});
      q.push_back('{1'($urandom), 1'b0, 1'b0});
      case (k)
        0, 1, 2, 3: begin
          rop = (k == 0) ? OP_R : (k == 1) ? OP_I : (k == 2) ? OP_LUI : OP_AUIPC;
          for (int j = 0; j < 2; j++) q.push_back('{1'($urandom), 1'b0, 1'b0});
        end
        4: begin
          rop = OP_BR;
          q.push_back('{1'($urandom), 1'b0, 1'b0});
        end
        5: begin
          rop = OP_JAL;
          for (int j = 0; j < 2; j++) q.push_back('{1'($urandom), 1'b0, 1'b0});
        end
        6: begin
          rop = OP_JALR;
          for (int j = 0; j < 3; j++) q.push_back('{1'($urandom), 1'b0, 1'b0});
        end
        7: rop = OP_FENCE;
        8: begin
          rop = OP_LD;
          q.push_back('{1'($urandom), 1'b0, 1'b0});
          for (int j = 0; j < w2; j++) q.push_back('{1'b0, 1'b1, 1'b0});
          q.push_back('{1'b1, 1'b1, 1'b0});
          q.push_back('{1'($urandom), 1'b0, 1'b0});
        end
        default: begin
          rop = OP_ST;
          q.push_back('{1'($urandom), 1'b0, 1'b0});
          for (int j = 0; j < w2; j++) q.push_back('{1'b0, 1'b0, 1'b1});
          q.push_back('{1'b1, 1'b0, 1'b1});
        end
      endcase
      foreach (q[j]) begin
        op0 = rop; f0 = rf3; rdy0 = q[j].rdy;
        #2;
        exp_ret = (j == 0) && !first;
        if (exp_ret) mcnt++;
        chk($sformatf("rand_i%0d_c%0d", n, j),
            {28'd0, d0_mem_read, d0_mem_write, d0_retire, d0_trap, d0_retire_count},
            {28'd0, q[j].mr, q[j].mw, exp_ret, 1'b0, 32'(mcnt)});
        tick();
      end
      first = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 0, means wait cycles with mem_ready low before a bus-error trap; 0 disables the timeout.
REQ-002 Parameter TRAP_ON_ILLEGAL, default 1, means 1 traps on an unknown opcode and 0 executes it as NOP.
REQ-003 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 opcode  in  7  IR[6:0]; funct3  in  3  IR[14:12]; mem_ready  in  1  bus transfer complete this cycle.
REQ-005 mem_read, mem_write, lord, ir_write, pc_write, pc_write_cond, pc_source, memory_to_reg, reg_write, is_immediate, branch_negate  out  1 each  datapath strobes and selects.
REQ-006 alu_src_a  out  2  00 PC, 01 rs1, 10 pc_old, 11 zero; alu_src_b  out  2  00 rs2, 01 const 4, 10 imm; aluop  out  2  00 add, 01 branch compare, 10 funct-decoded.
REQ-007 trap  out  1  core halted; trap_cause  out  2  00 none, 01 illegal, 10 bus timeout, 11 SYSTEM; retire  out  1  one-cycle retire pulse; retire_count  out  32  instructions retired.

Function
REQ-008 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR, JALR_LINK, LINK_WB, LUI, AUIPC and TRAP; all outputs not listed for a state SHALL be 0.
REQ-009 FETCH: mem_read=1, lord=0, a=00, b=01, aluop=00, and ir_write=pc_write=mem_ready; go to DECODE on mem_ready, otherwise hold.
REQ-010 DECODE: a=10, b=10, aluop=00 (target into ALU-out register); dispatch on opcode 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->MEM_ADDR, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->AUIPC, 0001111->FETCH (NOP), 1110011->TRAP (cause 11), other->TRAP (cause 01) or FETCH if TRAP_ON_ILLEGAL=0.
REQ-011 EXEC_R: a=01, b=00, aluop=10; EXEC_I: a=01, b=10, aluop=10, is_immediate=1; LUI: a=11, b=10; AUIPC: a=10, b=10; all four go to ALU_WB.
REQ-012 ALU_WB and LINK_WB: reg_write=1, memory_to_reg=0, then FETCH.
REQ-013 MEM_ADDR: a=01, b=10, aluop=00; go to MEM_RD for a load, MEM_WR for a store.
REQ-014 MEM_RD: lord=1, mem_read=1; go to MEM_WB on mem_ready. MEM_WB: reg_write=1, memory_to_reg=1, then FETCH.
REQ-015 MEM_WR: lord=1, mem_write=1; go to FETCH on mem_ready.
REQ-016 BRANCH: a=01, b=00, aluop=01, pc_write_cond=1, pc_source=1, branch_negate=funct3[0]^funct3[2], then FETCH.
REQ-017 JAL: pc_write=1, pc_source=1, a=10, b=01 (link), then LINK_WB.
REQ-018 JALR: a=01, b=10, pc_write=1, pc_source=0, then JALR_LINK. JALR_LINK: a=10, b=01, then LINK_WB.
REQ-019 retire SHALL pulse for one cycle on every transition into FETCH from a state other than FETCH or TRAP; retire_count SHALL increment on that cycle and wrap 2^32-1 -> 0.
REQ-020 With MEM_TIMEOUT=N>0, the wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and on mem_ready; after N consecutive cycles with mem_ready low the FSM SHALL go to TRAP with cause 10. mem_ready in the same cycle as expiry wins: no trap.
REQ-021 TRAP: trap=1, all strobes 0; hold until reset. trap_cause is latched on TRAP entry.
REQ-022 Output latency: all outputs are a combinational decode of the registered state, plus mem_ready where stated; state changes take one clk.

Reset
REQ-023 While reset is high, mem_read, mem_write, ir_write, pc_write, pc_write_cond and reg_write SHALL be forced to 0.
REQ-024 Reset asserted in any state, including TRAP or mid-wait, SHALL return the FSM to FETCH on the next edge and clear trap, trap_cause, retire, retire_count and the wait counter.

Structure
REQ-025 A shared package SHALL hold the state enum, the opcode constants, the alu_src_a/alu_src_b/aluop encodings and the trap_cause codes.
REQ-026 One sub-module, bus_timeout_counter (parameter N, inputs clear and enable, output expired), SHALL be instantiated only when MEM_TIMEOUT>0.

Verification
REQ-027 ADD (opcode 0110011), mem_ready tied 1 -> FETCH, DECODE, EXEC_R, ALU_WB, FETCH; retire pulses once; retire_count=1.
REQ-028 LW with mem_ready low for 3 cycles in MEM_RD -> mem_read and lord held 3 cycles, MEM_WB then has reg_write=1 and memory_to_reg=1.
REQ-029 BNE (funct3=001) -> BRANCH with pc_write_cond=1, branch_negate=1; BGE (101) -> branch_negate=0.
REQ-030 MEM_TIMEOUT=4 and mem_ready never high in FETCH -> TRAP after 4 cycles, trap_cause=10; then reset -> FETCH and trap=0.
REQ-031 Opcode 1111111 -> TRAP with cause 01 when TRAP_ON_ILLEGAL=1; DECODE -> FETCH with no trap and no retire-count change when TRAP_ON_ILLEGAL=0.
REQ-032 JALR -> JALR (pc_write=1, pc_source=0), JALR_LINK, LINK_WB (reg_write=1), FETCH; 2^32 retirements -> retire_count wraps to 0.
